// File: rtl/product_seg_scanner_if.sv
// Bus between the multiplier product source and the BCD/seven-segment display stage.
// The master drives the product and load strobe; the slave returns status, digits and the display bus.
interface product_seg_scanner_if;
    logic [5:0] p_in;
    logic       load;
    logic       busy;
    logic       valid;
    logic [3:0] bcd_t;
    logic [3:0] bcd_o;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output p_in, load,
        input  busy, valid, bcd_t, bcd_o, seg, an
    );

    modport slave (
        input  p_in, load,
        output busy, valid, bcd_t, bcd_o, seg, an
    );
endinterface

// File: rtl/product_seg_scanner.sv
// Serial binary-to-BCD conversion (shift-add-3) of a 6-bit product, feeding a
// time-multiplexed 2-digit common-anode seven-segment display.
module product_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    product_seg_scanner_if.slave  bus
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [5:0]    shift_q, shift_d;
    logic [7:0]    scratch_q, scratch_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [3:0]    bcd_t_q, bcd_t_d;
    logic [3:0]    bcd_o_q, bcd_o_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic          sel_q, sel_d;
    logic [7:0]    adj;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1111110;
            4'd1:    seg_code = 7'b0110000;
            4'd2:    seg_code = 7'b1101101;
            4'd3:    seg_code = 7'b1111001;
            4'd4:    seg_code = 7'b0110011;
            4'd5:    seg_code = 7'b1011011;
            4'd6:    seg_code = 7'b1011111;
            4'd7:    seg_code = 7'b1110000;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1111011;
            default: seg_code = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        bcd_t_d   = bcd_t_q;
        bcd_o_d   = bcd_o_q;
        adj[7:4]  = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
        adj[3:0]  = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d   = bus.p_in;
                    scratch_d = 8'd0;
                    cnt_d     = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // {scratch, shift} << 1 after the per-nibble add-3 correction
                scratch_d = {adj[6:0], shift_q[5]};
                shift_d   = {shift_q[4:0], 1'b0};
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    bcd_t_d = scratch_d[7:4];
                    bcd_o_d = scratch_d[3:0];
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Scan runs independently of the conversion FSM.
        if (ref_cnt_q == CW'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            sel_d     = ~sel_q;
        end else begin
            ref_cnt_d = ref_cnt_q + CW'(1);
            sel_d     = sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            bcd_t_q   <= '0;
            bcd_o_q   <= '0;
            ref_cnt_q <= '0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            bcd_t_q   <= bcd_t_d;
            bcd_o_q   <= bcd_o_d;
            ref_cnt_q <= ref_cnt_d;
            sel_q     <= sel_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.bcd_t = bcd_t_q;
    assign bus.bcd_o = bcd_o_q;

    // sel_q = 0 lights the ones digit, 1 the tens digit
    always_comb begin
        if (!sel_q) begin
            bus.an  = 2'b10;
            bus.seg = seg_code(bcd_o_q);
        end else if (BLANK_LZ && bcd_t_q == 4'd0) begin
            bus.an  = 2'b11;
            bus.seg = 7'b0000000;
        end else begin
            bus.an  = 2'b01;
            bus.seg = seg_code(bcd_t_q);
        end
    end
endmodule

// File: tb/tb_product_seg_scanner.sv
// Scoreboard bench: two instances (leading-zero blanking on/off) with a fast scan rate.
module tb_product_seg_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;

    product_seg_scanner_if if0();
    product_seg_scanner_if if1();

    assign if1.p_in = if0.p_in;
    assign if1.load = if0.load;

    product_seg_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    product_seg_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [3:0] disp_t = 4'd0;
    logic [3:0] disp_o = 4'd0;
    int   m_cnt;
    logic m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] code(input logic [3:0] d);
        case (d)
            4'd0: code = 7'b1111110;  4'd1: code = 7'b0110000;
            4'd2: code = 7'b1101101;  4'd3: code = 7'b1111001;
            4'd4: code = 7'b0110011;  4'd5: code = 7'b1011011;
            4'd6: code = 7'b1011111;  4'd7: code = 7'b1110000;
            4'd8: code = 7'b1111111;  4'd9: code = 7'b1111011;
            default: code = 7'b0000000;
        endcase
    endfunction

    // Expected scan phase: 4 cycles per digit, ones first after reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_sel <= 1'b0;
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            m_sel <= ~m_sel;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Monitor: pops on every valid pulse and checks the display each cycle
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            disp_t = 4'd0;
            disp_o = 4'd0;
        end else if (if0.valid) begin
            if (exp_q.size() == 0) begin
                check("valid_unexpected", {31'd0, if0.valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bcd_t", {28'd0, if0.bcd_t}, {28'd0, e[7:4]});
                check("bcd_o", {28'd0, if0.bcd_o}, {28'd0, e[3:0]});
                disp_t = e[7:4];
                disp_o = e[3:0];
            end
        end
        check("bcd_hold_t", {28'd0, if0.bcd_t}, {28'd0, disp_t});
        check("bcd_hold_o", {28'd0, if0.bcd_o}, {28'd0, disp_o});
        if (!m_sel) begin
            check("u0_an", {30'd0, if0.an}, 32'd2);
            check("u0_seg", {25'd0, if0.seg}, {25'd0, code(disp_o)});
            check("u1_an", {30'd0, if1.an}, 32'd2);
            check("u1_seg", {25'd0, if1.seg}, {25'd0, code(disp_o)});
        end else begin
            check("u0_an", {30'd0, if0.an}, (disp_t == 4'd0) ? 32'd3 : 32'd1);
            check("u0_seg", {25'd0, if0.seg}, (disp_t == 4'd0) ? 32'd0 : {25'd0, code(disp_t)});
            check("u1_an", {30'd0, if1.an}, 32'd1);
            check("u1_seg", {25'd0, if1.seg}, {25'd0, code(disp_t)});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((if0.busy || if0.valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", {31'd0, if0.busy}, 32'd0);
    endtask

    task automatic convert(input logic [5:0] p, input logic [3:0] t, input logic [3:0] o);
        wait_idle();
        if0.p_in = p;
        if0.load = 1'b1;
        exp_q.push_back({t, o});
        @(posedge clk);
        #1;
        if0.load = 1'b0;
        if0.p_in = ~p;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy_shift", {31'd0, if0.busy}, 32'd1);
        end
        @(negedge clk);
        check("busy_done", {31'd0, if0.busy}, 32'd0);
        check("valid_done", {31'd0, if0.valid}, 32'd1);
        @(negedge clk);
        check("valid_pulse_end", {31'd0, if0.valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if0.p_in = 6'd0;
        if0.load = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, if0.busy}, 32'd0);
        check("rst_valid", {31'd0, if0.valid}, 32'd0);
        check("rst_bcd", {24'd0, if0.bcd_t, if0.bcd_o}, 32'd0);
        check("rst_an", {30'd0, if0.an}, 32'd2);
        check("rst_seg", {25'd0, if0.seg}, 32'h7e);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_tens_blank", {30'd0, if0.an}, 32'd3);

        convert(6'd49, 4'd4, 4'd9);
        repeat (8) @(negedge clk);
        convert(6'd63, 4'd6, 4'd3);
        repeat (8) @(negedge clk);
        convert(6'd0, 4'd0, 4'd0);
        repeat (8) @(negedge clk);

        // load held through SHIFT and DONE: only the first product converts
        wait_idle();
        if0.p_in = 6'd12;
        if0.load = 1'b1;
        exp_q.push_back({4'd1, 4'd2});
        @(posedge clk);
        #1;
        if0.p_in = 6'd35;
        repeat (7) @(negedge clk);
        check("held_done_valid", {31'd0, if0.valid}, 32'd1);
        @(negedge clk);
        check("held_idle_busy", {31'd0, if0.busy}, 32'd0);
        if0.load = 1'b0;
        @(negedge clk);
        check("held_no_restart", {31'd0, if0.busy}, 32'd0);
        convert(6'd35, 4'd3, 4'd5);
        convert(6'd25, 4'd2, 4'd5);

        // reset in the middle of a conversion
        wait_idle();
        if0.p_in = 6'd36;
        if0.load = 1'b1;
        @(posedge clk);
        #1;
        if0.load = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_busy", {31'd0, if0.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, if0.busy}, 32'd0);
        check("abort_valid", {31'd0, if0.valid}, 32'd0);
        check("abort_bcd", {24'd0, if0.bcd_t, if0.bcd_o}, 32'd0);
        check("abort_an", {30'd0, if0.an}, 32'd2);
        check("abort_seg", {25'd0, if0.seg}, 32'h7e);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        convert(6'd36, 4'd3, 4'd6);
        repeat (10) @(negedge clk);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
